dram_banked: RTL and testbench

Parametrised multi-port, multi-group DRAM behavioural model. It generalises the fixed 16-port, 2-group byte memory in three ways: configurable port count, group count, data width, depth and access latency; a per-group busy indication; and a write-completion acknowledge. It sits below the field-extraction and serializer engines as their shared backing store in simulation. Each port group runs an independent latency state machine.

---
 rtl/dram_banked.sv | 146 ++++++++++++++
 tb/tb_dram_banked.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_banked.sv
// dram_banked: parametrised multi-port, multi-group DRAM behavioural model with per-group latency FSMs.
// Define DRAM_RANGE_CHECK_EN to flag out-of-range addresses on err instead of wrapping them.
module dram_banked #(
   parameter int NPORTS  = 16,
   parameter int NGROUPS = 2,
   parameter int DW      = 8,
   parameter int AW      = 64,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 20
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NPORTS-1:0]      en,
   input  logic [NGROUPS-1:0]     rdwr,
   input  logic [NPORTS*DW-1:0]   data_in,
   input  logic [NPORTS*AW-1:0]   addr,
   output logic [NPORTS*DW-1:0]   data_out,
   output logic [NPORTS-1:0]      valid,
   output logic [NGROUPS-1:0]     busy,
   output logic [NPORTS-1:0]      err
);
   // state | meaning
   // IDLE  | no request outstanding
   // WAIT  | request latched, counting down to the access edge
   // DONE  | access performed, valid high for this cycle
   localparam int P  = NPORTS / NGROUPS;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t             r_state     [NGROUPS];
   state_t             w_state_nxt [NGROUPS];
   logic [CW-1:0]      r_cnt       [NGROUPS];
   logic [NGROUPS-1:0] w_accept;
   logic [NGROUPS-1:0] w_fire;
   logic [NGROUPS-1:0] r_rd;
   logic [NPORTS-1:0]  r_mask;
   logic [NPORTS-1:0]  r_oor;
   logic [NPORTS-1:0]  w_oor_in;
   logic [NPORTS-1:0]  r_valid;
   logic [NPORTS-1:0]  r_err;
   logic [IW-1:0]      r_idx   [NPORTS];
   logic [DW-1:0]      r_wdata [NPORTS];
   logic [DW-1:0]      r_dout  [NPORTS];
   logic [DW-1:0]      r_mem   [DEPTH];

`ifdef DRAM_RANGE_CHECK_EN
   always_comb begin
      w_oor_in = '0;
      for (int p = 0; p < NPORTS; p++)
         w_oor_in[p] = (addr[p*AW +: AW] >= AW'(DEPTH));
   end
`else
   // Upper address bits are dropped: addresses wrap modulo DEPTH.
   logic w_unused_addr;
   assign w_oor_in      = '0;
   assign w_unused_addr = ^addr;
`endif

   always_comb begin
      for (int g = 0; g < NGROUPS; g++) begin
         w_state_nxt[g] = r_state[g];
         w_accept[g]    = 1'b0;
         w_fire[g]      = 1'b0;
         case (r_state[g])
            IDLE, DONE: begin
               w_state_nxt[g] = IDLE;
               if (|en[g*P +: P]) begin
                  w_state_nxt[g] = WAIT;
                  w_accept[g]    = 1'b1;
               end
            end
            WAIT: begin
               if (r_cnt[g] == '0) begin
                  w_state_nxt[g] = DONE;
                  w_fire[g]      = 1'b1;
               end
            end
            default: w_state_nxt[g] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int g = 0; g < NGROUPS; g++) begin
            r_state[g] <= IDLE;
            r_cnt[g]   <= '0;
         end
         r_rd    <= '0;
         r_mask  <= '0;
         r_oor   <= '0;
         r_valid <= '0;
         r_err   <= '0;
         for (int p = 0; p < NPORTS; p++) begin
            r_idx[p]   <= '0;
            r_wdata[p] <= '0;
            r_dout[p]  <= '0;
         end
      end else begin
         for (int g = 0; g < NGROUPS; g++) begin
            r_state[g] <= w_state_nxt[g];
            if (w_accept[g]) begin
               r_cnt[g]         <= CW'(LATENCY - 1);
               r_rd[g]          <= rdwr[g];
               r_mask[g*P +: P] <= en[g*P +: P];
            end else if (r_state[g] == WAIT && r_cnt[g] != '0) begin
               r_cnt[g] <= r_cnt[g] - CW'(1);
            end
         end
         for (int p = 0; p < NPORTS; p++) begin
            if (w_accept[p/P]) begin
               r_idx[p]   <= addr[p*AW +: IW];
               r_wdata[p] <= data_in[p*DW +: DW];
               r_oor[p]   <= w_oor_in[p];
            end
            r_valid[p] <= w_fire[p/P] & r_mask[p];
            r_err[p]   <= w_fire[p/P] & r_mask[p] & r_oor[p];
            // Reads see pre-edge memory, so they never observe a write committing on the same edge.
            if (w_fire[p/P] && r_rd[p/P] && r_mask[p])
               r_dout[p] <= r_oor[p] ? '0 : r_mem[r_idx[p]];
         end
      end
   end

   // Ascending port order makes the highest-numbered writer win on an address collision.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NPORTS; p++)
         if (!reset && w_fire[p/P] && !r_rd[p/P] && r_mask[p] && !r_oor[p])
            r_mem[r_idx[p]] <= r_wdata[p];
   end

   always_comb begin
      data_out = '0;
      busy     = '0;
      for (int p = 0; p < NPORTS; p++)
         data_out[p*DW +: DW] = r_dout[p];
      for (int g = 0; g < NGROUPS; g++)
         busy[g] = (r_state[g] != IDLE);
   end

   assign valid = r_valid;
   assign err   = r_err;

endmodule

// File: tb/tb_dram_banked.sv
// tb_dram_banked: vector table, hand sequences and random traffic against a timing-level reference model.
`timescale 1ns/1ps
module tb_dram_banked;
   localparam int NP = 16, NG = 2, DW = 8, AW = 64, DEPTH = 1024, LAT = 20;
   localparam int P = NP / NG;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NP-1:0]     en;
   logic [NG-1:0]     rdwr;
   logic [NP*DW-1:0]  data_in;
   logic [NP*AW-1:0]  addr;
   logic [NP*DW-1:0]  data_out;
   logic [NP-1:0]     valid;
   logic [NG-1:0]     busy;
   logic [NP-1:0]     err;

   always #5 clk = ~clk;

   dram_banked #(.NPORTS(NP), .NGROUPS(NG), .DW(DW), .AW(AW), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset), .en(en), .rdwr(rdwr), .data_in(data_in), .addr(addr),
      .data_out(data_out), .valid(valid), .busy(busy), .err(err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: each group is described by the edge its request was accepted on.
   int            k = 0;
   int            acc [NG];
   logic [NP-1:0] m_mask;
   logic [NG-1:0] m_rd;
   logic [AW-1:0] m_addr [NP];
   logic [DW-1:0] m_dat  [NP];
   logic [DW-1:0] mem_m  [DEPTH];
   bit            mem_k  [DEPTH];
   logic [DW-1:0] e_dout [NP];
   bit            e_known[NP];
   logic [NP-1:0] e_valid, e_err;

   function automatic bit oor(input logic [AW-1:0] a);
`ifdef DRAM_RANGE_CHECK_EN
      return a >= AW'(DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int widx(input logic [AW-1:0] a);
      return int'(a % AW'(DEPTH));
   endfunction

   task automatic model_reset();
      for (int g = 0; g < NG; g++) acc[g] = -1000;
      e_valid = '0;
      e_err   = '0;
      for (int p = 0; p < NP; p++) begin
         e_dout[p]  = '0;
         e_known[p] = 1'b1;
      end
   endtask

   task automatic model_edge();
      bit done [NG];
      k++;
      e_valid = '0;
      e_err   = '0;
      for (int g = 0; g < NG; g++) done[g] = (acc[g] + LAT == k);
      for (int p = 0; p < NP; p++) begin
         if (done[p/P] && m_mask[p]) begin
            e_valid[p] = 1'b1;
            e_err[p]   = oor(m_addr[p]);
            if (m_rd[p/P]) begin
               if (oor(m_addr[p])) begin
                  e_dout[p] = '0; e_known[p] = 1'b1;
               end else begin
                  e_dout[p] = mem_m[widx(m_addr[p])]; e_known[p] = mem_k[widx(m_addr[p])];
               end
            end
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (done[p/P] && m_mask[p] && !m_rd[p/P] && !oor(m_addr[p])) begin
            mem_m[widx(m_addr[p])] = m_dat[p];
            mem_k[widx(m_addr[p])] = 1'b1;
         end
      end
      for (int g = 0; g < NG; g++) begin
         if (en[g*P +: P] != '0 && k > acc[g] + LAT) begin
            acc[g]  = k;
            m_rd[g] = rdwr[g];
            for (int q = g*P; q < g*P + P; q++) begin
               m_mask[q] = en[q];
               m_addr[q] = addr[q*AW +: AW];
               m_dat[q]  = data_in[q*DW +: DW];
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      logic [NG-1:0] eb;
      for (int g = 0; g < NG; g++) eb[g] = (acc[g] <= k) && (k <= acc[g] + LAT);
      check("valid", 64'(valid), 64'(e_valid));
      check("busy", 64'(busy), 64'(eb));
      check("err", 64'(err), 64'(e_err));
      for (int p = 0; p < NP; p++)
         if (e_known[p]) check($sformatf("data_out[%0d]", p), 64'(data_out[p*DW +: DW]), 64'(e_dout[p]));
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else       model_edge();
      #1;
      compare();
   endtask

   task automatic clear_inputs();
      en = '0; rdwr = '0; addr = '0; data_in = '0;
   endtask

   task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
      en[p] = 1'b1;
      addr[p*AW +: AW] = a;
      data_in[p*DW +: DW] = d;
   endtask

   typedef struct {
      int            id;
      int            port;
      bit            rd;
      logic [AW-1:0] a;
      logic [DW-1:0] d;    // write data, or expected read data
   } op_t;
   op_t tbl[$];

   task automatic add(input int id, input int port, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      op_t o;
      o.id = id; o.port = port; o.rd = rd; o.a = a; o.d = d;
      tbl.push_back(o);
   endtask

   int            i, j, cyc, pulses;
   logic [NP-1:0] m;
   bit            busy_ok;
   logic [AW-1:0] ra;

   initial begin
      clear_inputs();
      for (int a = 0; a < DEPTH; a++) mem_k[a] = 1'b0;
      m_mask = '0; m_rd = '0;
      model_reset();
      repeat (3) tick();
      reset = 1'b0;

      add(1, 0, 0, 64'h0,   8'hde); add(1, 1, 0, 64'h1,   8'had);
      add(1, 8, 0, 64'h100, 8'hbe); add(1, 9, 0, 64'h101, 8'hef);
      add(2, 0, 1, 64'h0,   8'hde); add(2, 1, 1, 64'h1,   8'had);
      add(2, 8, 1, 64'h100, 8'hbe); add(2, 9, 1, 64'h101, 8'hef);
      add(3, 0, 0, 64'h0,   8'hba); add(3, 1, 0, 64'h1,   8'had);
      add(3, 8, 1, 64'h100, 8'hbe); add(3, 9, 1, 64'h101, 8'hef);
      add(4, 0, 1, 64'h0,   8'hba);
      add(5, 2, 0, 64'h7,   8'h11); add(5, 5, 0, 64'h7,   8'h55);
      add(6, 3, 1, 64'h7,   8'h55);
      add(7, 4, 0, 64'h3,   8'h33);
      add(8, 12, 1, 64'h3,  8'h33);
      add(9, 6, 0, 64'h405, 8'h77);
`ifdef DRAM_RANGE_CHECK_EN
      add(10, 15, 1, 64'h405, 8'h00);
`else
      add(10, 15, 1, 64'h5,   8'h77);
`endif

      i = 0;
      while (i < tbl.size()) begin
         j = i; m = '0;
         clear_inputs();
         while (j < tbl.size() && tbl[j].id == tbl[i].id) begin
            set_port(tbl[j].port, tbl[j].a, tbl[j].d);
            rdwr[tbl[j].port/P] = tbl[j].rd;
            m[tbl[j].port] = 1'b1;
            j++;
         end
         tick();
         clear_inputs();
         cyc = 0;
         tick(); cyc++;
         while ((valid & m) != m && cyc < 60) begin tick(); cyc++; end
         check($sformatf("latency vec%0d", tbl[i].id), 64'(cyc), 64'(LAT));
         for (int q = i; q < j; q++)
            if (tbl[q].rd) check($sformatf("rdata vec%0d port%0d", tbl[q].id, tbl[q].port),
                                 64'(data_out[tbl[q].port*DW +: DW]), 64'(tbl[q].d));
         repeat (2) tick();
         i = j;
      end

      // Request while busy is dropped: exactly one completion.
      clear_inputs(); set_port(0, 64'h0, 8'h0); rdwr[0] = 1'b1;
      tick(); clear_inputs();
      repeat (3) tick();
      set_port(0, 64'h1, 8'h0); rdwr[0] = 1'b1;
      tick(); clear_inputs();
      pulses = 0;
      repeat (30) begin tick(); pulses += int'(valid[0]); end
      check("dropped request pulses", 64'(pulses), 64'd1);

      // Back-to-back accept on the DONE cycle keeps busy high throughout.
      set_port(0, 64'h0, 8'h0); rdwr[0] = 1'b1;
      tick(); clear_inputs();
      cyc = 0;
      tick(); cyc++;
      while (!valid[0] && cyc < 60) begin tick(); cyc++; end
      check("b2b first latency", 64'(cyc), 64'(LAT));
      check("b2b first data", 64'(data_out[0 +: DW]), 64'hba);
      set_port(0, 64'h1, 8'h0); rdwr[0] = 1'b1;
      tick(); clear_inputs();
      busy_ok = busy[0];
      cyc = 0;
      tick(); cyc++; busy_ok &= busy[0];
      while (!valid[0] && cyc < 60) begin tick(); cyc++; busy_ok &= busy[0]; end
      check("b2b busy continuous", 64'(busy_ok), 64'd1);
      check("b2b second latency", 64'(cyc), 64'(LAT));
      check("b2b second data", 64'(data_out[0 +: DW]), 64'had);
      repeat (2) tick();

      // Reset five cycles into a write: no completion, memory untouched.
      set_port(0, 64'h3, 8'haa); rdwr = '0;
      tick(); clear_inputs();
      repeat (5) tick();
      #1 reset = 1'b1;
      #1;
      check("busy after reset", 64'(busy), 64'd0);
      check("valid after reset", 64'(valid), 64'd0);
      check("data_out after reset", 64'(data_out[0 +: DW]), 64'd0);
      model_reset();
      #1 reset = 1'b0;
      pulses = 0;
      repeat (30) begin tick(); pulses += int'(|valid); end
      check("valid after abandoned write", 64'(pulses), 64'd0);
      set_port(0, 64'h3, 8'h0); rdwr[0] = 1'b1;
      tick(); clear_inputs();
      cyc = 0;
      tick(); cyc++;
      while (!valid[0] && cyc < 60) begin tick(); cyc++; end
      check("mem[3] after reset", 64'(data_out[0 +: DW]), 64'h33);
      repeat (2) tick();

      for (int it = 0; it < 700; it++) begin
         clear_inputs();
         for (int g = 0; g < NG; g++)
            if ($urandom_range(0, 2) == 0) en[g*P +: P] = 8'($urandom) & 8'($urandom);
         rdwr = NG'($urandom);
         for (int p = 0; p < NP; p++) begin
            ra = 64'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ra += 64'(DEPTH) * 64'($urandom_range(1, 4));
            addr[p*AW +: AW] = ra;
            data_in[p*DW +: DW] = 8'($urandom);
         end
         tick();
      end
      clear_inputs();
      repeat (LAT + 3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
